// File: rtl/ux607_mrom_pkg.sv
// Shared types and helpers for the machine-ROM ICB front-end.
// Holds the response payload, the window decode and the error read data.
package ux607_mrom_pkg;

    localparam int unsigned ICB_AW = 32;
    localparam int unsigned ICB_DW = 32;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } icb_rsp_t;

    localparam logic [ICB_DW-1:0] ROM_ERR_RDATA = '0;

    // Window hit test done in 33 bits so a window near the top of the map cannot wrap.
    function automatic logic hit(
        input logic [ICB_AW-1:0] addr,
        input logic [ICB_AW-1:0] base,
        input int unsigned       dp
    );
        logic [ICB_AW:0] a;
        logic [ICB_AW:0] lo;
        logic [ICB_AW:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(dp) * 33'd4);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ux607_mrom_rsp_fifo.sv
// Circular response FIFO for the ROM bridge.
// Head data reads as zero while empty so the fabric side never shows stale payload.
module ux607_mrom_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);
    assign do_pop  = pop && !empty_c;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full_c || do_pop);
    assign head_c  = empty_c ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ux607_mrom_icb_bridge.sv
// Fabric-side ICB front-end for the machine ROM: window decode, local error
// responses, and a registered response path through a small FIFO.
module ux607_mrom_icb_bridge
    import ux607_mrom_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 32,
    parameter int unsigned DP        = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned FIFO_DP   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [31:0]   i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          i_icb_rsp_err,
    output logic [DW-1:0] i_icb_rsp_rdata,
    output logic          rom_icb_cmd_valid,
    input  logic          rom_icb_cmd_ready,
    output logic [AW-1:0] rom_icb_cmd_addr,
    output logic          rom_icb_cmd_read,
    input  logic          rom_icb_rsp_valid,
    output logic          rom_icb_rsp_ready,
    input  logic          rom_icb_rsp_err,
    input  logic [DW-1:0] rom_icb_rsp_rdata,
    output logic [7:0]    err_cnt
);

    logic     cmd_hit;
    logic     cmd_ok;
    logic     space;
    logic     rom_stall;
    logic     accept;
    logic     pop;
    logic     fifo_full;
    logic     fifo_empty;
    icb_rsp_t push_rsp;
    icb_rsp_t head_rsp;

    assign cmd_hit = hit(i_icb_cmd_addr, BASE_ADDR, DP);
    assign cmd_ok  = cmd_hit && i_icb_cmd_read && (i_icb_cmd_addr[1:0] == 2'b00);

    assign i_icb_rsp_valid = !fifo_empty;
    assign pop             = i_icb_rsp_valid && i_icb_rsp_ready;

    // No room is offered while reset is held, even though the FIFO reads as empty.
    assign space = !rst && (!fifo_full || pop);

    // An in-window read waits for the ROM; it must not complete without the ROM's data.
    assign rom_stall       = i_icb_cmd_valid && cmd_ok && !rom_icb_cmd_ready;
    assign i_icb_cmd_ready = space && !rom_stall;
    assign accept          = i_icb_cmd_valid && i_icb_cmd_ready;

    assign rom_icb_cmd_valid = i_icb_cmd_valid && cmd_ok && space;
    assign rom_icb_cmd_addr  = i_icb_cmd_addr[AW-1:0];
    assign rom_icb_cmd_read  = 1'b1;
    assign rom_icb_rsp_ready = space;

    // Response captured at accept: ROM data for good reads, a local error otherwise.
    always_comb begin
        push_rsp.err   = 1'b1;
        push_rsp.rdata = ROM_ERR_RDATA;
        if (cmd_ok) begin
            push_rsp.err   = rom_icb_rsp_err || !rom_icb_rsp_valid;
            push_rsp.rdata = ICB_DW'(rom_icb_rsp_rdata);
        end
    end

    ux607_mrom_rsp_fifo #(
        .WIDTH ($bits(icb_rsp_t)),
        .DEPTH (FIFO_DP)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_rsp),
        .pop       (pop),
        .head_c    (head_rsp),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    assign i_icb_rsp_err   = head_rsp.err;
    assign i_icb_rsp_rdata = DW'(head_rsp.rdata);

    // Saturating count of error responses actually taken by the fabric.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pop && head_rsp.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ux607_mrom_icb_bridge.sv
// Self-checking bench for ux607_mrom_icb_bridge: table of single accesses,
// a scoreboard for ordering/latency, and hand sequences for multi-cycle cases.
module tb_ux607_mrom_icb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_icb_cmd_valid;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr;
    logic        i_icb_cmd_read;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready;
    logic        i_icb_rsp_err;
    logic [31:0] i_icb_rsp_rdata;
    logic        rom_icb_cmd_valid;
    logic        rom_icb_cmd_ready;
    logic [11:0] rom_icb_cmd_addr;
    logic        rom_icb_cmd_read;
    logic        rom_icb_rsp_valid;
    logic        rom_icb_rsp_ready;
    logic        rom_icb_rsp_err;
    logic [31:0] rom_icb_rsp_rdata;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ux607_mrom_icb_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .i_icb_cmd_valid   (i_icb_cmd_valid),
        .i_icb_cmd_ready   (i_icb_cmd_ready),
        .i_icb_cmd_addr    (i_icb_cmd_addr),
        .i_icb_cmd_read    (i_icb_cmd_read),
        .i_icb_rsp_valid   (i_icb_rsp_valid),
        .i_icb_rsp_ready   (i_icb_rsp_ready),
        .i_icb_rsp_err     (i_icb_rsp_err),
        .i_icb_rsp_rdata   (i_icb_rsp_rdata),
        .rom_icb_cmd_valid (rom_icb_cmd_valid),
        .rom_icb_cmd_ready (rom_icb_cmd_ready),
        .rom_icb_cmd_addr  (rom_icb_cmd_addr),
        .rom_icb_cmd_read  (rom_icb_cmd_read),
        .rom_icb_rsp_valid (rom_icb_rsp_valid),
        .rom_icb_rsp_ready (rom_icb_rsp_ready),
        .rom_icb_rsp_err   (rom_icb_rsp_err),
        .rom_icb_rsp_rdata (rom_icb_rsp_rdata),
        .err_cnt           (err_cnt)
    );

    // ROM content pattern, indexed by word.
    function automatic logic [31:0] rom_word(input int unsigned idx);
        return 32'h5A00_0000 ^ (idx * 32'h0001_0203);
    endfunction

    // Combinational ROM model: cmd and rsp handshakes tied together.
    assign rom_icb_cmd_ready = rom_icb_rsp_ready;
    assign rom_icb_rsp_valid = rom_icb_cmd_valid;
    assign rom_icb_rsp_err   = 1'b0;
    assign rom_icb_rsp_rdata = rom_word(32'(rom_icb_cmd_addr[11:2]));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
        bit          strict;
    } sb_t;

    sb_t sb[$];

    logic        cur_ok;
    logic        cur_err;
    logic [31:0] cur_rdata;
    bit          strict = 1'b0;
    bit          tog    = 1'b0;
    logic [7:0]  exp_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare popped responses, track err_cnt, record accepts.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            sb.delete();
            exp_cnt = 8'd0;
        end else begin
            chk("err_cnt_track", 64'(err_cnt), 64'(exp_cnt));
            if (i_icb_rsp_valid && i_icb_rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(i_icb_rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_err", 64'(i_icb_rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(i_icb_rsp_rdata), 64'(e.rdata));
                    if (e.strict) chk("rsp_latency", 64'(cyc), 64'(e.acc_cyc + 1));
                    if (e.err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                end
            end
            if (i_icb_cmd_valid) begin
                chk("rom_cmd_valid", 64'(rom_icb_cmd_valid), 64'(i_icb_cmd_ready && cur_ok));
                if (i_icb_cmd_ready) sb.push_back('{cur_err, cur_rdata, cyc, strict});
            end
        end
    end

    function automatic logic model_ok(input logic [31:0] a, input logic rd);
        return ({1'b0, a} >= 33'h0_0000_1000) && ({1'b0, a} < 33'h0_0000_2000)
               && rd && (a[1:0] == 2'b00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) i_icb_rsp_ready = ~i_icb_rsp_ready;
    endtask

    task automatic send_exp(input logic [31:0] a, input logic rd, input logic e_err,
                            input logic [31:0] e_rdata, output int waited);
        logic acc;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = a;
        i_icb_cmd_read  = rd;
        cur_ok          = !e_err;
        cur_err         = e_err;
        cur_rdata       = e_rdata;
        waited          = 0;
        forever begin
            @(negedge clk);
            acc = i_icb_cmd_valid && i_icb_cmd_ready;
            tick();
            if (acc) break;
            waited++;
            if (waited > 200) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic rd, output int waited);
        logic ok;
        ok = model_ok(a, rd);
        send_exp(a, rd, !ok, ok ? rom_word(32'(a[11:2])) : 32'h0, waited);
    endtask

    task automatic idle(input int n);
        i_icb_cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n;
        i_icb_cmd_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 || i_icb_rsp_valid) begin
            tick();
            n++;
            if (n > 100) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                break;
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        read;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{32'h0000_1000, 1'b1, 1'b0, rom_word(0)};
        vecs[1] = '{32'h0000_1000, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{32'h0000_1002, 1'b1, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_1FFC, 1'b1, 1'b0, rom_word(1023)};
        vecs[4] = '{32'h0000_2000, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0};
        vecs[6] = '{32'h0000_0FFC, 1'b1, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_1800, 1'b1, 1'b0, rom_word(512)};
        vecs[8] = '{32'h0000_1003, 1'b0, 1'b1, 32'h0};

        rst             = 1'b1;
        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = 32'h0;
        i_icb_cmd_read  = 1'b0;
        i_icb_rsp_ready = 1'b0;
        cur_ok          = 1'b0;
        cur_err         = 1'b0;
        cur_rdata       = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        chk("reset_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt), 64'd0);
        chk("reset_rsp_rdata", 64'(i_icb_rsp_rdata), 64'd0);
        tick();
        rst = 1'b0;
        idle(1);

        // Table of single accesses, response ready throughout
        strict          = 1'b1;
        i_icb_rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_exp(vecs[i].addr, vecs[i].read, vecs[i].exp_err, vecs[i].exp_rdata, w);
            chk("table_first_try", 64'(w), 64'd0);
            idle(1);
        end
        drain();

        // Streaming: back-to-back reads
        for (int i = 0; i < 3; i++) begin
            send(32'h0000_1000 + 32'(i * 4), 1'b1, w);
            chk("stream_cmd_ready", 64'(w), 64'd0);
        end
        drain();

        // Backpressure: two fill the FIFO, third waits for the first pop
        strict          = 1'b0;
        i_icb_rsp_ready = 1'b0;
        send(32'h0000_1010, 1'b1, w);
        chk("bp_first", 64'(w), 64'd0);
        send(32'h0000_1014, 1'b1, w);
        chk("bp_second", 64'(w), 64'd0);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = 32'h0000_1018;
        i_icb_cmd_read  = 1'b1;
        cur_ok          = 1'b1;
        cur_err         = 1'b0;
        cur_rdata       = rom_word(6);
        repeat (3) begin
            @(negedge clk);
            chk("bp_cmd_ready_low", 64'(i_icb_cmd_ready), 64'd0);
            chk("bp_rsp_valid", 64'(i_icb_rsp_valid), 64'd1);
            tick();
        end
        i_icb_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_with_pop", 64'(i_icb_cmd_ready), 64'd1);
        tick();
        drain();

        // Reset mid-burst with two entries queued
        i_icb_rsp_ready = 1'b0;
        send(32'h0000_1020, 1'b0, w);
        send(32'h0000_1024, 1'b1, w);
        idle(1);
        @(negedge clk);
        chk("mid_rsp_valid_before", 64'(i_icb_rsp_valid), 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        chk("mid_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
        chk("mid_rsp_err", 64'(i_icb_rsp_err), 64'd0);
        tick();
        rst             = 1'b0;
        i_icb_rsp_ready = 1'b1;
        strict          = 1'b1;
        tick();
        send(32'h0000_1000, 1'b1, w);
        i_icb_cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 64'(i_icb_rsp_valid), 64'd1);
        chk("post_reset_rdata", 64'(i_icb_rsp_rdata), 64'(rom_word(0)));
        drain();

        // Saturating error counter
        for (int i = 0; i < 260; i++) begin
            send(32'h0000_1000 + 32'((i % 16) * 4), 1'b0, w);
        end
        drain();
        idle(1);
        @(negedge clk);
        chk("err_cnt_saturated", 64'(err_cnt), 64'hFF);

        // Pointer wrap with toggling response ready
        strict = 1'b0;
        tog    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(32'h0000_1100 + 32'(i * 4), 1'b1, w);
        end
        drain();
        tog             = 1'b0;
        i_icb_rsp_ready = 1'b1;
        idle(2);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
